// File: rtl/iz_param_loader.sv
// Byte-serial loader for the Izhikevich neuron parameters (a, b, c, d).
// Frames are HEADER + eight big-endian data bytes + an XOR checksum. The four
// words are assembled in shadow registers and reach the outputs all at once,
// only after the checksum matches.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for HEADER; other bytes are accepted and dropped
//   LOAD   | collecting data bytes 0..7 into the shadow registers
//   CHECK  | next accepted byte is compared against the running XOR
//   COMMIT | single cycle, input stalled, shadow words copied to outputs
//
// The inter-byte timeout is a down-counter. Each accepted byte reloads it
// with TIMEOUT_CYCLES-1, and each idle cycle decrements it. An idle cycle
// that finds it already at zero is the TIMEOUT_CYCLES-th idle cycle, so the
// frame is aborted on that edge.
module iz_param_loader #(
   parameter logic [7:0]         HEADER         = 8'hA5,
   parameter int                 TIMEOUT_CYCLES = 1024,
   parameter logic signed [15:0] DEFAULT_A      = 16'sd1,
   parameter logic signed [15:0] DEFAULT_B      = 16'sd13,
   parameter logic signed [15:0] DEFAULT_C      = -16'sd4160,
   parameter logic signed [15:0] DEFAULT_D      = 16'sd512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic        in_ready,
   output logic [15:0] param_a,
   output logic [15:0] param_b,
   output logic [15:0] param_c,
   output logic [15:0] param_d,
   output logic        params_ready,
   output logic        load_busy,
   output logic        load_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      xor_q, xor_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0][7:0] shadow_q, shadow_d;
   logic [15:0]     param_a_q, param_a_d;
   logic [15:0]     param_b_q, param_b_d;
   logic [15:0]     param_c_q, param_c_d;
   logic [15:0]     param_d_q, param_d_d;
   logic            ready_q, ready_d;
   logic            err_q, err_d;
   logic            accept;

   assign in_ready     = (state_q != ST_COMMIT);
   assign accept       = data_valid && in_ready;
   assign load_busy    = (state_q != ST_IDLE);
   assign load_error   = err_q;
   assign params_ready = ready_q;
   assign param_a      = param_a_q;
   assign param_b      = param_b_q;
   assign param_c      = param_c_q;
   assign param_d      = param_d_q;

   // Frame parsing, checksum, timeout and commit decisions.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      xor_d     = xor_q;
      tmo_d     = tmo_q;
      shadow_d  = shadow_q;
      param_a_d = param_a_q;
      param_b_d = param_b_q;
      param_c_d = param_c_q;
      param_d_d = param_d_q;
      ready_d   = ready_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            tmo_d = TMO_LOAD;
            if (accept && data_in == HEADER) begin
               state_d = ST_LOAD;
               idx_d   = 3'd0;
               xor_d   = 8'h00;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               shadow_d[idx_q] = data_in;
               xor_d           = xor_q ^ data_in;
               idx_d           = idx_q + 3'd1;
               tmo_d           = TMO_LOAD;
               if (idx_q == 3'd7) state_d = ST_CHECK;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         ST_CHECK: begin
            if (accept) begin
               tmo_d = TMO_LOAD;
               if (data_in == xor_q) begin
                  state_d = ST_COMMIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         ST_COMMIT: begin
            param_a_d = {shadow_q[0], shadow_q[1]};
            param_b_d = {shadow_q[2], shadow_q[3]};
            param_c_d = {shadow_q[4], shadow_q[5]};
            param_d_d = {shadow_q[6], shadow_q[7]};
            ready_d   = 1'b1;
            tmo_d     = TMO_LOAD;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= 3'd0;
         xor_q     <= 8'h00;
         tmo_q     <= TMO_LOAD;
         shadow_q  <= '0;
         param_a_q <= DEFAULT_A;
         param_b_q <= DEFAULT_B;
         param_c_q <= DEFAULT_C;
         param_d_q <= DEFAULT_D;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         xor_q     <= xor_d;
         tmo_q     <= tmo_d;
         shadow_q  <= shadow_d;
         param_a_q <= param_a_d;
         param_b_q <= param_b_d;
         param_c_q <= param_c_d;
         param_d_q <= param_d_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
      end
   end

endmodule
